cnn_result_collector: RTL and testbench
=======================================

Name: cnn_result_collector

Overview:
- Downstream stage of the CNN core. Consumes the two-score-per-beat output stream (valid_o, data1_o, data2_o) for one inference frame.
- Buffers all class scores and computes the signed argmax.
- Holds the winning class, its score and the score buffer stable for scan-chain readout until the next frame start.

Parameters:
- NUM_CLASSES, 10, number of class scores per frame; must be even and ≥2.
- DATA_W, 8, score width, two's-complement signed.
- ADDR_W, 4, index width; must satisfy 2^ADDR_W ≥ NUM_CLASSES.

Ports:
- clk  input  1  system clock, same domain as the CNN core.
- rst  input  1  synchronous, active-high reset.
- sta_i  input  1  frame start pulse, same pulse that starts the CNN core.
- valid_i  input  1  score beat valid, driven by core valid_o.
- data1_i  input  DATA_W  score for even index idx.
- data2_i  input  DATA_W  score for odd index idx+1.
- rd_addr  input  ADDR_W  score buffer read index.
- rd_en  input  1  read strobe.
- rd_data  output  DATA_W  registered read data.
- busy_o  output  1  high while collecting.
- done_o  output  1  frame complete; sticky.
- class_o  output  ADDR_W  argmax index.
- max_o  output  DATA_W  argmax score.
- frame_cnt  output  8  completed-frame counter.
- err_o  output  1  sticky protocol-error flag.

Behaviour:
- Reset (rst=1 at a clk edge) forces all of the following to 0:
  - FSM state → IDLE; busy_o, done_o, class_o, max_o, rd_data, frame_cnt, err_o.
  - Beat index idx and every score buffer entry.
- Reset takes priority over every other input, including a frame in progress.
- FSM states: IDLE, COLLECT, DONE.
- Starting a frame (IDLE or DONE, sta_i=1): next cycle state=COLLECT, busy_o=1, done_o=0, idx=0. class_o, max_o and the buffer keep their old values until overwritten.
- Restarting (COLLECT, sta_i=1): the current frame is discarded, idx=0, state stays COLLECT, err_o is set.
- sta_i and valid_i in the same cycle: sta_i wins and that beat is dropped.
- Collecting beats (COLLECT, valid_i=1, sta_i=0):
  - Write buf[idx]=data1_i and buf[idx+1]=data2_i, then idx += 2.
  - Argmax update within the beat, evaluated combinationally and registered:
    - Candidate c1 = data1_i at index idx.
    - On the first beat (idx=0), c1 unconditionally becomes the running max.
    - Otherwise c1 replaces the running max only if strictly greater (signed).
    - Then c2 = data2_i at index idx+1 replaces the result of the c1 step only if strictly greater.
    - Ties therefore keep the lower index.
- Frame completion: the beat that writes index NUM_CLASSES-1 is the final beat.
  - On the edge that captures it, class_o and max_o update, state=DONE, busy_o=0, done_o=1, frame_cnt += 1 (wraps 255→0).
  - done_o is asserted in the cycle immediately after the final beat's valid_i cycle (1-cycle latency).
- Stray beats: valid_i in IDLE or DONE is ignored and sets err_o; buffer and results are unchanged.
- err_o clears only on rst.
- Score buffer reads:
  - rd_en=1 → rd_data = buf[rd_addr] on the next cycle.
  - rd_addr ≥ NUM_CLASSES → rd_data = 0.
  - rd_en=0 → rd_data holds its value.
  - Reads are legal in any state.
  - A read of an index written on the same edge returns the old value.
- All comparisons are signed over DATA_W. No saturation or arithmetic widening is required.

Test Plan:
- Nominal frame: rst, then sta_i. Then 5 consecutive beats carrying (data1, data2) pairs (3,-5), (7,2), (-128,127), (0,1), (9,4) → done_o=1 one cycle after beat 5; class_o=5, max_o=127, frame_cnt=1, err_o=0; busy_o was high from the cycle after sta_i through beat 5.
- Ties and negatives: all 10 scores = -3 → class_o=0, max_o=-3 (0xFD). Then a frame with scores idx4=idx7=50 and all others -1 → class_o=4.
- Gapped valid and readback: beats separated by 0–3 idle cycles give the same result as back-to-back beats. After done: rd_addr=0..11 with rd_en → rd_data equals the written scores for 0..9 and 0 for 10..11, each one cycle after rd_en.
- Restart mid-frame: sta_i after 2 beats, then a full 5-beat frame → results reflect only the second frame; err_o=1; frame_cnt increments by 1.
- Stray beat and simultaneous events:
  - valid_i in DONE → class_o, max_o and buffer unchanged; err_o=1.
  - sta_i and valid_i in the same cycle → beat dropped; the next 5 beats complete the frame.
- Reset mid-operation: rst after 3 beats → all outputs 0, state IDLE. A following valid_i sets err_o. Then sta_i plus a full frame yields correct results and frame_cnt=1. Separately, frame_cnt wraps 255→0 after 256 frames.

Source files
------------

// File: rtl/cnn_result_collector.sv
// Collects one frame of two-per-beat CNN class scores, tracks the signed argmax,
// and holds results plus the score buffer stable for readout until the next frame.
module cnn_result_collector #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sta_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] class_o,
  output logic [DATA_W-1:0] max_o,
  output logic [7:0]        frame_cnt,
  output logic              err_o
);

  localparam int unsigned     CNT_W      = 8;
  localparam logic [ADDR_W:0] NUM_CLS_EX = (ADDR_W+1)'(NUM_CLASSES);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_CLASSES - 2);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] run_max_q, run_max_d;
  logic [ADDR_W-1:0] run_cls_q, run_cls_d;
  logic [ADDR_W-1:0] class_q, class_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] score_q [NUM_CLASSES];

  logic beat, final_beat, restart, stray;
  logic c1_wins, c2_wins;
  logic [DATA_W-1:0] m1, m2;
  logic [ADDR_W-1:0] k1, k2;
  logic [ADDR_W-1:0] idx_odd;
  logic              rd_in_range;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; sta_i always wins over valid_i
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (sta_i) state_d = COLLECT;
      end
      COLLECT: begin
        if (sta_i)                          state_d = COLLECT;
        else if (valid_i && idx_q == LAST_IDX) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control decode from current state and inputs
  always_comb begin
    beat       = 1'b0;
    final_beat = 1'b0;
    restart    = 1'b0;
    stray      = 1'b0;
    case (state_q)
      COLLECT: begin
        restart    = sta_i;
        beat       = valid_i && !sta_i;
        final_beat = beat && (idx_q == LAST_IDX);
      end
      IDLE, DONE: begin
        stray = valid_i && !sta_i;
      end
      default: ;
    endcase
  end

  // Argmax within a beat: c1 then c2, strict compare keeps the lower index on ties
  always_comb begin
    idx_odd = idx_q + ADDR_W'(1);
    c1_wins = (idx_q == '0) || ($signed(data1_i) > $signed(run_max_q));
    m1      = c1_wins ? data1_i : run_max_q;
    k1      = c1_wins ? idx_q   : run_cls_q;
    c2_wins = $signed(data2_i) > $signed(m1);
    m2      = c2_wins ? data2_i : m1;
    k2      = c2_wins ? idx_odd : k1;
  end

  // Next values for the datapath registers
  always_comb begin
    idx_d       = idx_q;
    run_max_d   = run_max_q;
    run_cls_d   = run_cls_q;
    class_d     = class_q;
    max_d       = max_q;
    frame_cnt_d = frame_cnt_q;
    err_d       = err_q || restart || stray;
    busy_d      = (state_d == COLLECT);
    done_d      = (state_d == DONE);
    if (sta_i) begin
      idx_d = '0;
    end else if (beat) begin
      idx_d     = idx_q + ADDR_W'(2);
      run_max_d = m2;
      run_cls_d = k2;
      if (final_beat) begin
        class_d     = k2;
        max_d       = m2;
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      run_max_q   <= '0;
      run_cls_q   <= '0;
      class_q     <= '0;
      max_q       <= '0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      run_max_q   <= run_max_d;
      run_cls_q   <= run_cls_d;
      class_q     <= class_d;
      max_q       <= max_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Score buffer: one even/odd pair written per accepted beat
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_CLASSES); i++) score_q[i] <= '0;
    end else if (beat) begin
      score_q[idx_q]   <= data1_i;
      score_q[idx_odd] <= data2_i;
    end
  end

  // Registered readout; out-of-range indices read as zero
  assign rd_in_range = ({1'b0, rd_addr} < NUM_CLS_EX);

  always_ff @(posedge clk) begin
    if (rst)        rd_data_q <= '0;
    else if (rd_en) rd_data_q <= rd_in_range ? score_q[rd_addr] : '0;
  end

  assign rd_data   = rd_data_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign class_o   = class_q;
  assign max_o     = max_q;
  assign frame_cnt = frame_cnt_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_cnn_result_collector.sv
// Directed bench for cnn_result_collector: argmax, ties, gaps, readback,
// restart, stray beats, reset mid-frame and frame counter wrap.
module tb_cnn_result_collector;

  logic       clk;
  logic       rst;
  logic       sta_i;
  logic       valid_i;
  logic [7:0] data1_i;
  logic [7:0] data2_i;
  logic [3:0] rd_addr;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       busy_o;
  logic       done_o;
  logic [3:0] class_o;
  logic [7:0] max_o;
  logic [7:0] frame_cnt;
  logic       err_o;

  int checks = 0;
  int fails  = 0;
  logic [7:0] sc [10];

  cnn_result_collector #(.NUM_CLASSES(10), .DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .sta_i(sta_i), .valid_i(valid_i),
    .data1_i(data1_i), .data2_i(data2_i), .rd_addr(rd_addr), .rd_en(rd_en),
    .rd_data(rd_data), .busy_o(busy_o), .done_o(done_o), .class_o(class_o),
    .max_o(max_o), .frame_cnt(frame_cnt), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic do_start();
    sta_i = 1'b1; tick(); sta_i = 1'b0;
  endtask

  task automatic do_beat(input logic [7:0] a, input logic [7:0] b);
    data1_i = a; data2_i = b; valid_i = 1'b1; tick(); valid_i = 1'b0;
  endtask

  // Sends sc[] as 5 beats; gap_mode inserts b%4 idle cycles after beat b
  task automatic run_frame(input bit gap_mode);
    for (int b = 0; b < 5; b++) begin
      do_beat(sc[2*b], sc[2*b+1]);
      if (gap_mode && b < 4) repeat (b % 4) tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (busy_o !== 1'b0)  begin fails++; $display("FAIL reset_busy got %0d exp 0", busy_o); end
    checks++; if (done_o !== 1'b0)  begin fails++; $display("FAIL reset_done got %0d exp 0", done_o); end
    checks++; if (class_o !== 4'd0) begin fails++; $display("FAIL reset_class got %0d exp 0", class_o); end
    checks++; if (max_o !== 8'd0)   begin fails++; $display("FAIL reset_max got %0h exp 0", max_o); end
    checks++; if (rd_data !== 8'd0) begin fails++; $display("FAIL reset_rd_data got %0h exp 0", rd_data); end
    checks++; if (frame_cnt !== 8'd0) begin fails++; $display("FAIL reset_frame_cnt got %0d exp 0", frame_cnt); end
    checks++; if (err_o !== 1'b0)   begin fails++; $display("FAIL reset_err got %0d exp 0", err_o); end
  endtask

  task automatic test_nominal();
    sc = '{8'd3, 8'hFB, 8'd7, 8'd2, 8'h80, 8'h7F, 8'd0, 8'd1, 8'd9, 8'd4};
    do_start();
    checks++; if (busy_o !== 1'b1 || done_o !== 1'b0) begin fails++; $display("FAIL nominal_start busy/done got %0d/%0d exp 1/0", busy_o, done_o); end
    for (int b = 0; b < 4; b++) begin
      do_beat(sc[2*b], sc[2*b+1]);
      checks++; if (busy_o !== 1'b1 || done_o !== 1'b0) begin fails++; $display("FAIL nominal_busy beat %0d busy/done got %0d/%0d exp 1/0", b, busy_o, done_o); end
    end
    do_beat(sc[8], sc[9]);
    checks++; if (done_o !== 1'b1 || busy_o !== 1'b0) begin fails++; $display("FAIL nominal_done done/busy got %0d/%0d exp 1/0", done_o, busy_o); end
    checks++; if (class_o !== 4'd5) begin fails++; $display("FAIL nominal_class got %0d exp 5", class_o); end
    checks++; if (max_o !== 8'h7F)  begin fails++; $display("FAIL nominal_max got %0h exp 7f", max_o); end
    checks++; if (frame_cnt !== 8'd1) begin fails++; $display("FAIL nominal_frame_cnt got %0d exp 1", frame_cnt); end
    checks++; if (err_o !== 1'b0)   begin fails++; $display("FAIL nominal_err got %0d exp 0", err_o); end
  endtask

  task automatic test_ties();
    for (int i = 0; i < 10; i++) sc[i] = 8'hFD;
    do_start(); run_frame(1'b0);
    checks++; if (class_o !== 4'd0) begin fails++; $display("FAIL ties_all_class got %0d exp 0", class_o); end
    checks++; if (max_o !== 8'hFD)  begin fails++; $display("FAIL ties_all_max got %0h exp fd", max_o); end
    for (int i = 0; i < 10; i++) sc[i] = 8'hFF;
    sc[4] = 8'd50; sc[7] = 8'd50;
    do_start(); run_frame(1'b0);
    checks++; if (class_o !== 4'd4) begin fails++; $display("FAIL ties_50_class got %0d exp 4", class_o); end
    checks++; if (max_o !== 8'd50)  begin fails++; $display("FAIL ties_50_max got %0d exp 50", max_o); end
    checks++; if (frame_cnt !== 8'd3) begin fails++; $display("FAIL ties_frame_cnt got %0d exp 3", frame_cnt); end
  endtask

  task automatic test_gapped_readback();
    sc = '{8'd10, 8'hEC, 8'd30, 8'hD8, 8'd55, 8'd5, 8'hF9, 8'd54, 8'd0, 8'hFF};
    do_start(); run_frame(1'b1);
    checks++; if (done_o !== 1'b1)  begin fails++; $display("FAIL gapped_done got %0d exp 1", done_o); end
    checks++; if (class_o !== 4'd4) begin fails++; $display("FAIL gapped_class got %0d exp 4", class_o); end
    checks++; if (max_o !== 8'd55)  begin fails++; $display("FAIL gapped_max got %0d exp 55", max_o); end
    for (int a = 0; a < 12; a++) begin
      logic [7:0] exp_v;
      exp_v = (a < 10) ? sc[a] : 8'd0;
      rd_addr = 4'(a); rd_en = 1'b1; tick(); rd_en = 1'b0;
      checks++; if (rd_data !== exp_v) begin fails++; $display("FAIL readback addr %0d got %0h exp %0h", a, rd_data, exp_v); end
    end
    rd_addr = 4'd2; rd_en = 1'b1; tick();
    rd_en = 1'b0; rd_addr = 4'd4; tick();
    checks++; if (rd_data !== 8'd30) begin fails++; $display("FAIL readback_hold got %0h exp 1e", rd_data); end
  endtask

  task automatic test_back_to_back();
    do_start(); run_frame(1'b0);
    checks++; if (class_o !== 4'd4 || max_o !== 8'd55) begin fails++; $display("FAIL b2b_result class/max got %0d/%0d exp 4/55", class_o, max_o); end
    checks++; if (frame_cnt !== 8'd5) begin fails++; $display("FAIL b2b_frame_cnt got %0d exp 5", frame_cnt); end
  endtask

  task automatic test_restart();
    do_start();
    do_beat(8'd100, 8'd100);
    do_beat(8'd100, 8'd100);
    do_start();
    checks++; if (err_o !== 1'b1 || busy_o !== 1'b1) begin fails++; $display("FAIL restart_err/busy got %0d/%0d exp 1/1", err_o, busy_o); end
    sc = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'hF7};
    run_frame(1'b0);
    checks++; if (class_o !== 4'd8 || max_o !== 8'd9) begin fails++; $display("FAIL restart_result class/max got %0d/%0d exp 8/9", class_o, max_o); end
    checks++; if (frame_cnt !== 8'd6) begin fails++; $display("FAIL restart_frame_cnt got %0d exp 6", frame_cnt); end
    rd_addr = 4'd0; rd_en = 1'b1; tick(); rd_en = 1'b0;
    checks++; if (rd_data !== 8'd1) begin fails++; $display("FAIL restart_buf0 got %0d exp 1", rd_data); end
  endtask

  task automatic test_stray_simul();
    do_reset();
    sc = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'hF7};
    do_start(); run_frame(1'b0);
    checks++; if (err_o !== 1'b0) begin fails++; $display("FAIL stray_pre_err got %0d exp 0", err_o); end
    do_beat(8'd120, 8'd120);
    checks++; if (err_o !== 1'b1) begin fails++; $display("FAIL stray_err got %0d exp 1", err_o); end
    checks++; if (class_o !== 4'd8 || max_o !== 8'd9 || done_o !== 1'b1) begin fails++; $display("FAIL stray_hold class/max/done got %0d/%0d/%0d exp 8/9/1", class_o, max_o, done_o); end
    rd_addr = 4'd1; rd_en = 1'b1; tick(); rd_en = 1'b0;
    checks++; if (rd_data !== 8'd2) begin fails++; $display("FAIL stray_buf1 got %0d exp 2", rd_data); end
    // sta_i with valid_i: the beat is dropped and five more beats are needed
    sc = '{8'hFB, 8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'hFA, 8'hF9, 8'hF8, 8'hF7, 8'hF6};
    data1_i = 8'd120; data2_i = 8'd120; sta_i = 1'b1; valid_i = 1'b1; tick();
    sta_i = 1'b0; valid_i = 1'b0;
    for (int b = 0; b < 4; b++) do_beat(sc[2*b], sc[2*b+1]);
    checks++; if (done_o !== 1'b0) begin fails++; $display("FAIL simul_early_done got %0d exp 0", done_o); end
    do_beat(sc[8], sc[9]);
    checks++; if (done_o !== 1'b1) begin fails++; $display("FAIL simul_done got %0d exp 1", done_o); end
    checks++; if (class_o !== 4'd4 || max_o !== 8'hFF) begin fails++; $display("FAIL simul_result class/max got %0d/%0h exp 4/ff", class_o, max_o); end
    rd_addr = 4'd0; rd_en = 1'b1; tick(); rd_en = 1'b0;
    checks++; if (rd_data !== 8'hFB) begin fails++; $display("FAIL simul_buf0 got %0h exp fb", rd_data); end
  endtask

  task automatic test_reset_mid();
    do_start();
    do_beat(8'd11, 8'd12); do_beat(8'd13, 8'd14); do_beat(8'd15, 8'd16);
    do_reset();
    checks++; if (busy_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0) begin fails++; $display("FAIL rstmid_flags busy/done/err got %0d/%0d/%0d exp 0/0/0", busy_o, done_o, err_o); end
    checks++; if (class_o !== 4'd0 || max_o !== 8'd0 || frame_cnt !== 8'd0 || rd_data !== 8'd0) begin fails++; $display("FAIL rstmid_regs class/max/cnt/rd got %0d/%0h/%0d/%0h exp 0/0/0/0", class_o, max_o, frame_cnt, rd_data); end
    rd_addr = 4'd0; rd_en = 1'b1; tick(); rd_en = 1'b0;
    checks++; if (rd_data !== 8'd0) begin fails++; $display("FAIL rstmid_buf0 got %0h exp 0", rd_data); end
    do_beat(8'd1, 8'd1);
    checks++; if (err_o !== 1'b1 || busy_o !== 1'b0) begin fails++; $display("FAIL rstmid_stray err/busy got %0d/%0d exp 1/0", err_o, busy_o); end
    sc = '{8'd3, 8'hFB, 8'd7, 8'd2, 8'h80, 8'h7F, 8'd0, 8'd1, 8'd9, 8'd4};
    do_start(); run_frame(1'b0);
    checks++; if (class_o !== 4'd5 || max_o !== 8'h7F || frame_cnt !== 8'd1) begin fails++; $display("FAIL rstmid_frame class/max/cnt got %0d/%0h/%0d exp 5/7f/1", class_o, max_o, frame_cnt); end
  endtask

  task automatic test_wrap();
    do_reset();
    sc = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    for (int f = 0; f < 255; f++) begin do_start(); run_frame(1'b0); end
    checks++; if (frame_cnt !== 8'd255) begin fails++; $display("FAIL wrap_255 got %0d exp 255", frame_cnt); end
    do_start(); run_frame(1'b0);
    checks++; if (frame_cnt !== 8'd0) begin fails++; $display("FAIL wrap_0 got %0d exp 0", frame_cnt); end
    checks++; if (class_o !== 4'd9 || max_o !== 8'd9) begin fails++; $display("FAIL wrap_result class/max got %0d/%0d exp 9/9", class_o, max_o); end
  endtask

  initial begin
    rst = 1'b1; sta_i = 1'b0; valid_i = 1'b0;
    data1_i = '0; data2_i = '0; rd_addr = '0; rd_en = 1'b0;
    test_reset();
    test_nominal();
    test_ties();
    test_gapped_readback();
    test_back_to_back();
    test_restart();
    test_stray_simul();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
